// File: rtl/aes_hwpe_pkg.sv
// Shared types and defaults for the AES engine TCDM master-port slice.
// Widths here describe the default engine configuration.
package aes_hwpe_pkg;

    localparam int AES_ADDR_W          = 32;
    localparam int AES_DATA_W          = 32;
    localparam int AES_BE_W            = AES_DATA_W / 8;
    localparam int AES_MAX_OUT_DEFAULT = 4;

    // Outstanding counters never exceed 15, so four bits always suffice.
    localparam int AES_CNT_W = 4;

    typedef struct packed {
        logic [AES_ADDR_W-1:0] add;
        logic                  wen;
        logic [AES_BE_W-1:0]   be;
        logic [AES_DATA_W-1:0] data;
    } tcdm_req_t;

endpackage

// File: rtl/aes_tcdm_port_slice.sv
// One TCDM channel: 2-entry request skid buffer, registered response path,
// outstanding-credit limiting and a sticky spurious-response flag.
module aes_tcdm_port_slice
    import aes_hwpe_pkg::*;
#(
    parameter int ADDR_W  = AES_ADDR_W,
    parameter int DATA_W  = AES_DATA_W,
    parameter int MAX_OUT = AES_MAX_OUT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  in_req_i,
    output logic                  in_gnt_o,
    input  logic [ADDR_W-1:0]     in_add_i,
    input  logic                  in_wen_i,
    input  logic [DATA_W/8-1:0]   in_be_i,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic [DATA_W-1:0]     in_r_data_o,
    output logic                  in_r_valid_o,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_W-1:0]     tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [DATA_W/8-1:0]   tcdm_be_o,
    output logic [DATA_W-1:0]     tcdm_data_o,
    input  logic [DATA_W-1:0]     tcdm_r_data_i,
    input  logic                  tcdm_r_valid_i,
    output logic                  err_o,
    output logic                  idle_nxt_o
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [AES_CNT_W-1:0] MAX_OUT_C = AES_CNT_W'(MAX_OUT);
    localparam logic [AES_CNT_W-1:0] CNT_ONE   = AES_CNT_W'(1);

    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic              wen;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                 r_buf [2];
    logic [1:0]             r_fill;
    logic                   r_req;
    logic [AES_CNT_W-1:0]   r_out;
    logic                   r_err;
    logic                   r_rvalid;
    logic [DATA_W-1:0]      r_rdata;

    entry_t                 w_new;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_slot;
    logic                   w_ret;
    logic                   w_spur;
    logic [AES_CNT_W-1:0]   w_issued;
    logic [AES_CNT_W-1:0]   w_out_nxt;
    logic [1:0]             w_fill_nxt;

    assign w_new    = '{add: in_add_i, wen: in_wen_i, be: in_be_i, data: in_data_i};
    assign in_gnt_o = (r_fill < 2'd2) && (r_out < MAX_OUT_C);
    assign w_push   = in_req_i && in_gnt_o;
    assign w_pop    = r_req && tcdm_gnt_i;

    // Entry 0 is always the head; a push lands behind whatever survives the pop.
    assign w_slot   = w_pop ? (r_fill == 2'd2) : (r_fill == 2'd1);

    assign w_issued = r_out - {{(AES_CNT_W-2){1'b0}}, r_fill};
    assign w_ret    = tcdm_r_valid_i && (w_issued != '0);
    assign w_spur   = tcdm_r_valid_i && (w_issued == '0);

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + 2'd1;
        end else if (!w_push && w_pop) begin
            w_fill_nxt = r_fill - 2'd1;
        end
    end

    always_comb begin
        w_out_nxt = r_out;
        if (w_push && !w_ret) begin
            w_out_nxt = r_out + CNT_ONE;
        end else if (!w_push && w_ret) begin
            w_out_nxt = r_out - CNT_ONE;
        end
    end

    assign idle_nxt_o = (w_out_nxt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_fill   <= 2'd0;
            r_req    <= 1'b0;
            r_out    <= '0;
        end else begin
            r_fill <= w_fill_nxt;
            r_req  <= (w_fill_nxt != 2'd0);
            r_out  <= w_out_nxt;
            if (w_pop) begin
                r_buf[0] <= r_buf[1];
            end
            if (w_push) begin
                r_buf[w_slot] <= w_new;
            end
        end
    end

    // A new spurious response takes priority over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_spur) begin
                r_err <= 1'b1;
            end else if (clr_i) begin
                r_err <= 1'b0;
            end
            r_rvalid <= tcdm_r_valid_i;
            if (tcdm_r_valid_i) begin
                r_rdata <= tcdm_r_data_i;
            end
        end
    end

    assign tcdm_req_o   = r_req;
    assign tcdm_add_o   = r_buf[0].add;
    assign tcdm_wen_o   = r_buf[0].wen;
    assign tcdm_be_o    = r_buf[0].be;
    assign tcdm_data_o  = r_buf[0].data;
    assign in_r_valid_o = r_rvalid;
    assign in_r_data_o  = r_rdata;
    assign err_o        = r_err;

endmodule

// File: rtl/aes_tcdm_slice.sv
// Registered TCDM master-port stage between the AES streamers and the cluster
// interconnect: MP independent channel slices plus a shared idle indication.
module aes_tcdm_slice
    import aes_hwpe_pkg::*;
#(
    parameter int MP      = 2,
    parameter int ADDR_W  = AES_ADDR_W,
    parameter int DATA_W  = AES_DATA_W,
    parameter int MAX_OUT = AES_MAX_OUT_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic [MP-1:0]              in_req_i,
    output logic [MP-1:0]              in_gnt_o,
    input  logic [MP*ADDR_W-1:0]       in_add_i,
    input  logic [MP-1:0]              in_wen_i,
    input  logic [MP*(DATA_W/8)-1:0]   in_be_i,
    input  logic [MP*DATA_W-1:0]       in_data_i,
    output logic [MP*DATA_W-1:0]       in_r_data_o,
    output logic [MP-1:0]              in_r_valid_o,
    output logic [MP-1:0]              tcdm_req_o,
    input  logic [MP-1:0]              tcdm_gnt_i,
    output logic [MP*ADDR_W-1:0]       tcdm_add_o,
    output logic [MP-1:0]              tcdm_wen_o,
    output logic [MP*(DATA_W/8)-1:0]   tcdm_be_o,
    output logic [MP*DATA_W-1:0]       tcdm_data_o,
    input  logic [MP*DATA_W-1:0]       tcdm_r_data_i,
    input  logic [MP-1:0]              tcdm_r_valid_i,
    output logic [MP-1:0]              err_o,
    output logic                       idle_o
);

    localparam int BE_W = DATA_W / 8;

    logic [MP-1:0] w_idle_nxt;
    logic          r_idle;

    for (genvar p = 0; p < MP; p++) begin : g_ch
        aes_tcdm_port_slice #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .MAX_OUT (MAX_OUT)
        ) u_slice (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .clr_i          (clr_i),
            .in_req_i       (in_req_i[p]),
            .in_gnt_o       (in_gnt_o[p]),
            .in_add_i       (in_add_i[p*ADDR_W +: ADDR_W]),
            .in_wen_i       (in_wen_i[p]),
            .in_be_i        (in_be_i[p*BE_W +: BE_W]),
            .in_data_i      (in_data_i[p*DATA_W +: DATA_W]),
            .in_r_data_o    (in_r_data_o[p*DATA_W +: DATA_W]),
            .in_r_valid_o   (in_r_valid_o[p]),
            .tcdm_req_o     (tcdm_req_o[p]),
            .tcdm_gnt_i     (tcdm_gnt_i[p]),
            .tcdm_add_o     (tcdm_add_o[p*ADDR_W +: ADDR_W]),
            .tcdm_wen_o     (tcdm_wen_o[p]),
            .tcdm_be_o      (tcdm_be_o[p*BE_W +: BE_W]),
            .tcdm_data_o    (tcdm_data_o[p*DATA_W +: DATA_W]),
            .tcdm_r_data_i  (tcdm_r_data_i[p*DATA_W +: DATA_W]),
            .tcdm_r_valid_i (tcdm_r_valid_i[p]),
            .err_o          (err_o[p]),
            .idle_nxt_o     (w_idle_nxt[p])
        );
    end

    // Registered from next-state counters so idle_o tracks outstanding==0 exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idle <= 1'b1;
        end else begin
            r_idle <= &w_idle_nxt;
        end
    end

    assign idle_o = r_idle;

endmodule

// File: tb/tb_aes_tcdm_slice.sv
// Self-checking bench for aes_tcdm_slice: scenario tasks with inline checks,
// plus request/response scoreboards fed at stimulus time and drained on DUT output.
module tb_aes_tcdm_slice;

    localparam int MP   = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 4;

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } req_s;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic [MP-1:0]     in_req = '0;
    logic [MP-1:0]     in_gnt;
    logic [MP*AW-1:0]  in_add = '0;
    logic [MP-1:0]     in_wen = '0;
    logic [MP*BW-1:0]  in_be = '0;
    logic [MP*DW-1:0]  in_data = '0;
    logic [MP*DW-1:0]  in_r_data;
    logic [MP-1:0]     in_r_valid;
    logic [MP-1:0]     tcdm_req;
    logic [MP-1:0]     tcdm_gnt = '0;
    logic [MP*AW-1:0]  tcdm_add;
    logic [MP-1:0]     tcdm_wen;
    logic [MP*BW-1:0]  tcdm_be;
    logic [MP*DW-1:0]  tcdm_data;
    logic [MP*DW-1:0]  tcdm_r_data = '0;
    logic [MP-1:0]     tcdm_r_valid = '0;
    logic [MP-1:0]     err;
    logic              idle;

    int checks = 0;
    int errors = 0;

    req_s        reqQ [MP][$];
    logic [DW-1:0] rspQ [MP][$];

    aes_tcdm_slice #(
        .MP      (MP),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_OUT (MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clr_i          (clr),
        .in_req_i       (in_req),
        .in_gnt_o       (in_gnt),
        .in_add_i       (in_add),
        .in_wen_i       (in_wen),
        .in_be_i        (in_be),
        .in_data_i      (in_data),
        .in_r_data_o    (in_r_data),
        .in_r_valid_o   (in_r_valid),
        .tcdm_req_o     (tcdm_req),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_r_data_i  (tcdm_r_data),
        .tcdm_r_valid_i (tcdm_r_valid),
        .err_o          (err),
        .idle_o         (idle)
    );

    always #5 clk = ~clk;

    // Scoreboards: requests and responses are queued when the handshake is
    // driven and compared when the DUT presents them; reset drops everything.
    always @(negedge clk) begin
        req_s          obs;
        req_s          expReq;
        logic [DW-1:0] expRsp;
        if (rst) begin
            for (int p = 0; p < MP; p++) begin
                reqQ[p].delete();
                rspQ[p].delete();
            end
        end else begin
            for (int p = 0; p < MP; p++) begin
                if (tcdm_req[p] && tcdm_gnt[p]) begin
                    obs = '{add: tcdm_add[p*AW +: AW], wen: tcdm_wen[p],
                            be: tcdm_be[p*BW +: BW], data: tcdm_data[p*DW +: DW]};
                    checks++;
                    if (reqQ[p].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_issue ch%0d: got request %h, required none pending", p, obs);
                    end else begin
                        expReq = reqQ[p].pop_front();
                        if (obs !== expReq) begin
                            errors++;
                            $display("[TB] FAIL sb_issue ch%0d: got %h, required %h", p, obs, expReq);
                        end
                    end
                end
                if (in_req[p] && in_gnt[p]) begin
                    reqQ[p].push_back('{add: in_add[p*AW +: AW], wen: in_wen[p],
                                        be: in_be[p*BW +: BW], data: in_data[p*DW +: DW]});
                end
                if (in_r_valid[p]) begin
                    checks++;
                    if (rspQ[p].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_resp ch%0d: got %h, required no response", p, in_r_data[p*DW +: DW]);
                    end else begin
                        expRsp = rspQ[p].pop_front();
                        if (in_r_data[p*DW +: DW] !== expRsp) begin
                            errors++;
                            $display("[TB] FAIL sb_resp ch%0d: got %h, required %h", p, in_r_data[p*DW +: DW], expRsp);
                        end
                    end
                end
                if (tcdm_r_valid[p]) begin
                    rspQ[p].push_back(tcdm_r_data[p*DW +: DW]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (tcdm_req !== 2'b00) begin errors++; $display("[TB] FAIL reset_tcdm_req: got %b, required 00", tcdm_req); end
        checks++;
        if (in_r_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_r_valid: got %b, required 00", in_r_valid); end
        checks++;
        if (in_r_data !== '0) begin errors++; $display("[TB] FAIL reset_r_data: got %h, required 0", in_r_data); end
        checks++;
        if (err !== 2'b00) begin errors++; $display("[TB] FAIL reset_err: got %b, required 00", err); end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b, required 1", idle); end
        checks++;
        if (in_gnt !== 2'b11) begin errors++; $display("[TB] FAIL reset_gnt: got %b, required 11", in_gnt); end
    endtask

    task automatic test_single_read();
        in_req[0] = 1'b1;
        in_add[0 +: AW] = 32'h1000;
        in_wen[0] = 1'b1;
        in_be[0 +: BW] = 4'hF;
        in_data[0 +: DW] = 32'h0;
        tcdm_gnt[0] = 1'b1;
        tick();
        in_req[0] = 1'b0;
        checks++;
        if (tcdm_req[0] !== 1'b1) begin errors++; $display("[TB] FAIL read_req_latency: got %b, required 1", tcdm_req[0]); end
        checks++;
        if (tcdm_add[0 +: AW] !== 32'h1000) begin errors++; $display("[TB] FAIL read_add: got %h, required 00001000", tcdm_add[0 +: AW]); end
        checks++;
        if (idle !== 1'b0) begin errors++; $display("[TB] FAIL read_busy: got idle=%b, required 0", idle); end
        tick();
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_data[0 +: DW] = 32'hDEADBEEF;
        checks++;
        if (tcdm_req[0] !== 1'b0) begin errors++; $display("[TB] FAIL read_req_drop: got %b, required 0", tcdm_req[0]); end
        tick();
        tcdm_r_valid[0] = 1'b0;
        checks++;
        if (in_r_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL read_rvalid: got %b, required 1", in_r_valid[0]); end
        checks++;
        if (in_r_data[0 +: DW] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_rdata: got %h, required deadbeef", in_r_data[0 +: DW]); end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL read_idle: got %b, required 1", idle); end
        tick();
        checks++;
        if (in_r_valid[0] !== 1'b0 || in_r_data[0 +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_rdata_hold: got valid=%b data=%h, required valid=0 data=deadbeef", in_r_valid[0], in_r_data[0 +: DW]);
        end
        tcdm_gnt[0] = 1'b0;
    endtask

    task automatic test_credit_limit();
        int grants = 0;
        logic acc;
        tcdm_gnt[0] = 1'b1;
        in_req[0] = 1'b1;
        in_wen[0] = 1'b0;
        in_add[0 +: AW] = 32'h2000;
        in_data[0 +: DW] = 32'h11110000;
        for (int i = 0; i < 8; i++) begin
            acc = in_gnt[0];
            tick();
            if (acc) begin
                grants++;
                in_add[0 +: AW] = in_add[0 +: AW] + 32'd4;
                in_data[0 +: DW] = in_data[0 +: DW] + 32'd1;
            end
        end
        checks++;
        if (grants != MAXO) begin errors++; $display("[TB] FAIL credit_grants: got %0d, required %0d", grants, MAXO); end
        checks++;
        if (in_gnt[0] !== 1'b0) begin errors++; $display("[TB] FAIL credit_full_gnt: got %b, required 0", in_gnt[0]); end
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_data[0 +: DW] = 32'hA0000001;
        tick();
        tcdm_r_valid[0] = 1'b0;
        checks++;
        if (in_gnt[0] !== 1'b1) begin errors++; $display("[TB] FAIL credit_restore: got %b, required 1", in_gnt[0]); end
        tick();
        in_req[0] = 1'b0;
        checks++;
        if (in_gnt[0] !== 1'b0) begin errors++; $display("[TB] FAIL credit_one_only: got %b, required 0", in_gnt[0]); end
        for (int k = 0; k < MAXO; k++) begin
            tcdm_r_valid[0] = 1'b1;
            tcdm_r_data[0 +: DW] = 32'hA0000002 + 32'(k);
            tick();
        end
        tcdm_r_valid[0] = 1'b0;
        tick();
        checks++;
        if (idle !== 1'b1 || err !== 2'b00) begin errors++; $display("[TB] FAIL credit_drain: got idle=%b err=%b, required idle=1 err=00", idle, err); end
        tcdm_gnt[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        int accepts = 0;
        logic acc;
        tcdm_gnt[0] = 1'b0;
        in_req[0] = 1'b1;
        in_wen[0] = 1'b1;
        in_add[0 +: AW] = 32'h0;
        in_data[0 +: DW] = 32'h55AA0000;
        for (int i = 0; i < 5; i++) begin
            acc = in_gnt[0];
            tick();
            if (acc) begin
                accepts++;
                in_add[0 +: AW] = in_add[0 +: AW] + 32'd4;
                in_data[0 +: DW] = in_data[0 +: DW] + 32'd1;
            end
            checks++;
            if (tcdm_add[0 +: AW] !== 32'h0) begin errors++; $display("[TB] FAIL bp_add_stable: got %h, required 00000000", tcdm_add[0 +: AW]); end
        end
        in_req[0] = 1'b0;
        checks++;
        if (accepts != 2) begin errors++; $display("[TB] FAIL bp_accepts: got %0d, required 2", accepts); end
        checks++;
        if (in_gnt[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_fill_gnt: got %b, required 0", in_gnt[0]); end
        tcdm_gnt[0] = 1'b1;
        tick();
        checks++;
        if (tcdm_req[0] !== 1'b1 || tcdm_add[0 +: AW] !== 32'h4) begin
            errors++;
            $display("[TB] FAIL bp_drain_second: got req=%b add=%h, required req=1 add=00000004", tcdm_req[0], tcdm_add[0 +: AW]);
        end
        tick();
        checks++;
        if (tcdm_req[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_empty: got %b, required 0", tcdm_req[0]); end
        tcdm_gnt[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tcdm_r_valid[0] = 1'b1;
            tcdm_r_data[0 +: DW] = 32'hB0000000 + 32'(k);
            tick();
        end
        tcdm_r_valid[0] = 1'b0;
        tick();
        checks++;
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL bp_idle: got %b, required 1", idle); end
    endtask

    task automatic test_spurious();
        tcdm_r_valid[1] = 1'b1;
        tcdm_r_data[DW +: DW] = 32'hBAD00001;
        tick();
        tcdm_r_valid[1] = 1'b0;
        checks++;
        if (err !== 2'b10) begin errors++; $display("[TB] FAIL spur_err: got %b, required 10", err); end
        checks++;
        if (in_r_valid[1] !== 1'b1 || in_r_data[DW +: DW] !== 32'hBAD00001) begin
            errors++;
            $display("[TB] FAIL spur_forward: got valid=%b data=%h, required valid=1 data=bad00001", in_r_valid[1], in_r_data[DW +: DW]);
        end
        checks++;
        if (in_gnt[1] !== 1'b1 || idle !== 1'b1) begin errors++; $display("[TB] FAIL spur_outstanding: got gnt=%b idle=%b, required 1 1", in_gnt[1], idle); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (err !== 2'b00) begin errors++; $display("[TB] FAIL spur_clr: got %b, required 00", err); end
        clr = 1'b1;
        tcdm_r_valid[1] = 1'b1;
        tcdm_r_data[DW +: DW] = 32'hBAD00002;
        tick();
        clr = 1'b0;
        tcdm_r_valid[1] = 1'b0;
        checks++;
        if (err !== 2'b10) begin errors++; $display("[TB] FAIL spur_err_wins: got %b, required 10", err); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (err !== 2'b00) begin errors++; $display("[TB] FAIL spur_clr2: got %b, required 00", err); end
    endtask

    task automatic test_simultaneous();
        tcdm_gnt[0] = 1'b1;
        in_req[0] = 1'b1;
        in_wen[0] = 1'b1;
        in_add[0 +: AW] = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            tick();
            in_add[0 +: AW] = in_add[0 +: AW] + 32'd4;
        end
        checks++;
        if (in_gnt[0] !== 1'b1) begin errors++; $display("[TB] FAIL sim_pre_gnt: got %b, required 1", in_gnt[0]); end
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_data[0 +: DW] = 32'hC0000001;
        tick();
        tcdm_r_valid[0] = 1'b0;
        in_add[0 +: AW] = in_add[0 +: AW] + 32'd4;
        checks++;
        if (in_gnt[0] !== 1'b1) begin errors++; $display("[TB] FAIL sim_gnt_held: got %b, required 1", in_gnt[0]); end
        tick();
        in_req[0] = 1'b0;
        checks++;
        if (in_gnt[0] !== 1'b0) begin errors++; $display("[TB] FAIL sim_out_was_3: got gnt=%b, required 0", in_gnt[0]); end
        checks++;
        if (in_gnt[1] !== 1'b1 || tcdm_req[1] !== 1'b0 || err !== 2'b00) begin
            errors++;
            $display("[TB] FAIL sim_ch1_isolated: got gnt1=%b req1=%b err=%b, required 1 0 00", in_gnt[1], tcdm_req[1], err);
        end
        for (int k = 0; k < MAXO; k++) begin
            tcdm_r_valid[0] = 1'b1;
            tcdm_r_data[0 +: DW] = 32'hC0000002 + 32'(k);
            tick();
        end
        tcdm_r_valid[0] = 1'b0;
        tick();
        checks++;
        if (idle !== 1'b1 || err !== 2'b00) begin errors++; $display("[TB] FAIL sim_drain: got idle=%b err=%b, required 1 00", idle, err); end
        tcdm_gnt[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        tcdm_gnt[0] = 1'b1;
        in_req[0] = 1'b1;
        in_wen[0] = 1'b0;
        in_add[0 +: AW] = 32'h4000;
        for (int i = 0; i < 3; i++) begin
            tick();
            in_add[0 +: AW] = in_add[0 +: AW] + 32'd4;
        end
        tcdm_gnt[0] = 1'b0;
        tick();
        in_req[0] = 1'b0;
        checks++;
        if (in_gnt[0] !== 1'b0 || tcdm_req[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_setup: got gnt=%b req=%b, required 0 1", in_gnt[0], tcdm_req[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (tcdm_req !== 2'b00) begin errors++; $display("[TB] FAIL mid_req: got %b, required 00", tcdm_req); end
        checks++;
        if (in_gnt !== 2'b11) begin errors++; $display("[TB] FAIL mid_gnt: got %b, required 11", in_gnt); end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL mid_idle: got %b, required 1", idle); end
        tcdm_r_valid[0] = 1'b1;
        tcdm_r_data[0 +: DW] = 32'hE0000001;
        tick();
        tcdm_r_valid[0] = 1'b0;
        checks++;
        if (err !== 2'b01) begin errors++; $display("[TB] FAIL mid_late_err: got %b, required 01", err); end
        checks++;
        if (in_r_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL mid_late_fwd: got %b, required 1", in_r_valid[0]); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_credit_limit();
        test_backpressure();
        test_spurious();
        test_simultaneous();
        test_reset_mid();
        tick();
        for (int p = 0; p < MP; p++) begin
            checks++;
            if (reqQ[p].size() != 0 || rspQ[p].size() != 0) begin
                errors++;
                $display("[TB] FAIL sb_leftover ch%0d: got req=%0d rsp=%0d pending, required 0 0", p, reqQ[p].size(), rspQ[p].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_tcdm_slice.md
Name: aes_tcdm_slice

Overview:
- Parametrised, registered TCDM master-port stage between the AES engine streamers and the cluster interconnect.
- Generalises the flattened port binding to MP channels of configurable address/data width.
- Adds three functions per channel:
  - a 2-entry request skid buffer;
  - a registered response path;
  - outstanding-transaction credit limiting, with sticky protocol-error detection and an idle indication for the control unit.

Parameters:
MP, 2, number of TCDM channels
ADDR_W, 32, address width
DATA_W, 32, data width; byte enable width is DATA_W/8
MAX_OUT, 4, maximum outstanding transactions per channel (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
clr_i  in  1  synchronous clear of err_o only
in_req_i  in  MP  engine request
in_gnt_o  out  MP  engine grant
in_add_i  in  MP x ADDR_W  engine address
in_wen_i  in  MP  1 = read, 0 = write
in_be_i  in  MP x DATA_W/8  byte enables
in_data_i  in  MP x DATA_W  write data
in_r_data_o  out  MP x DATA_W  response data
in_r_valid_o  out  MP  response valid
tcdm_req_o  out  MP  memory request
tcdm_gnt_i  in  MP  memory grant
tcdm_add_o  out  MP x ADDR_W  memory address
tcdm_wen_o  out  MP  memory wen
tcdm_be_o  out  MP x DATA_W/8  memory byte enables
tcdm_data_o  out  MP x DATA_W  memory write data
tcdm_r_data_i  in  MP x DATA_W  memory response data
tcdm_r_valid_i  in  MP  memory response valid
err_o  out  MP  sticky: response received with nothing issued
idle_o  out  1  all channels have zero outstanding and empty buffers

Behaviour:
- Channels are fully independent; all statements below apply per channel p.
- Reset (rst_i=1 at a clock edge): buffer empty, counters 0, err_o=0, in_r_valid_o=0, in_r_data_o=0, tcdm_req_o=0. idle_o=1 in the cycle after reset.
- Reset mid-operation discards buffered requests and in-flight credits with no flush. Responses arriving after reset with issued==0 set err_o.
- Counters:
  - fill (0..2): entries in the skid buffer.
  - outstanding (0..MAX_OUT): accepted from the engine, response not yet received.
  - issued = outstanding - fill; it is never negative.
- Engine accept: in_gnt_o = (fill<2) && (outstanding<MAX_OUT). It is a function of registers only; there is no combinational path from tcdm_gnt_i.
- A transfer occurs when in_req_i && in_gnt_o. The entry {add, wen, be, data} is written to the buffer tail, fill++, outstanding++.
- Memory issue: tcdm_req_o = (fill>0); tcdm_* fields present the head entry and are registered outputs.
  - On tcdm_req_o && tcdm_gnt_i the head is popped and fill--.
  - Fields stay stable while tcdm_req_o=1 and tcdm_gnt_i=0.
- Request latency: an engine transfer at edge t makes tcdm_req_o high from t+1 at the earliest.
- Throughput: one request per cycle sustained when tcdm_gnt_i is held high (push and pop in the same cycle, fill unchanged).
- Order: FIFO, with no reordering within a channel.
- Response: tcdm_r_valid_i is registered into in_r_valid_o and in_r_data_o, one-cycle latency.
  - in_r_data_o holds its last value when in_r_valid_o=0.
  - Every granted request, read or write, yields exactly one r_valid.
- Credit return: on tcdm_r_valid_i with issued>0, outstanding--. A simultaneous accept and credit return leaves outstanding unchanged.
- Protocol error: tcdm_r_valid_i with issued==0 sets err_o[p] (sticky) and leaves outstanding unchanged. The response is still forwarded to the engine.
  - clr_i clears err_o. If clr_i and a new error occur in the same cycle, the error wins.
- idle_o: registered. It is 1 when all channels have outstanding==0.
- Full boundary: at outstanding==MAX_OUT, in_gnt_o=0 until a response arrives. in_gnt_o rises in the cycle after the response edge.
- Fill boundary: fill==2 with tcdm_gnt_i=0 holds in_gnt_o=0.

Decomposition:
- Package aes_hwpe_pkg:
  - tcdm_req_t struct {add, wen, be, data} parametrised via localparams AES_ADDR_W=32, AES_DATA_W=32;
  - AES_MAX_OUT_DEFAULT=4.
- Sub-module aes_tcdm_port_slice: one channel, containing the skid buffer, counters and error flag.
- The top generates MP instances and ANDs their idle terms.

Test Plan:
- Single read (MP=2, ch0): in_req with add=0x1000, wen=1; tcdm_gnt=1; r_valid 2 cycles later with r_data=0xDEADBEEF.
  - Required: tcdm_req_o high 1 cycle after accept.
  - Required: in_r_valid_o=1 with 0xDEADBEEF 1 cycle after tcdm_r_valid; idle_o returns to 1.
- Credit limit (MAX_OUT=4): in_req held high, tcdm_gnt=1, no responses.
  - Required: exactly 4 grants, then in_gnt_o=0.
  - One response restores one grant in the next cycle.
- Backpressure: tcdm_gnt=0 for 5 cycles with the engine requesting.
  - Required: 2 accepts, then in_gnt_o=0; tcdm_add_o stable.
  - Releasing gnt drains in order (add 0x0, then 0x4).
- Spurious response: tcdm_r_valid on ch1 with no issued request.
  - Required: err_o=2'b10 next cycle, outstanding stays 0, response forwarded.
  - clr_i clears err_o to 0.
- Simultaneous accept and response at outstanding=3: outstanding stays 3 and in_gnt_o stays 1.
  - Channel 0 traffic leaves channel 1 counters unchanged.
- Reset mid-burst (fill=2, outstanding=4): assert rst_i for 1 cycle.
  - Required: tcdm_req_o=0, in_gnt_o=1 and idle_o=1 the next cycle.
  - A late response sets err_o.
